// File: rtl/network_vn_arbiter_pkg.sv
// ============================================================================
// Module      : network_vn_arbiter_pkg
// Description : Flit type encodings, arbiter state and bus slicing helpers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package network_vn_arbiter_pkg;

  localparam logic [1:0] HEADER      = 2'd0;
  localparam logic [1:0] BODY        = 2'd1;
  localparam logic [1:0] TAIL        = 2'd2;
  localparam logic [1:0] HEADER_TAIL = 2'd3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Low bit position of slice vn in a flattened bus of width-bit fields.
  function automatic int unsigned vn_lsb(input int unsigned vn, input int unsigned width);
    return vn * width;
  endfunction

  function automatic logic is_header_type(input logic [1:0] flit_type);
    return (flit_type == HEADER) || (flit_type == HEADER_TAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/network_vn_packet_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick starting at a supplied pointer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [IDX_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [IDX_WIDTH-1:0] o_grant_idx,
  output logic                 o_grant_valid
);

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    // Offset i from the pointer selects candidate (ptr + i) mod N.
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_grant_valid && i_req[j] &&
            (j == ((int'(i_ptr) + i) % NUM_REQ))) begin
          o_grant_valid = 1'b1;
          o_grant[j]    = 1'b1;
          o_grant_idx   = IDX_WIDTH'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/network_vn_packet_arbiter.sv
// ============================================================================
// Module      : network_vn_packet_arbiter
// Description : Packet-granular round-robin merge of per-VN flit streams
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module network_vn_packet_arbiter
  import network_vn_arbiter_pkg::*;
#(
  parameter int FlitWidth               = 64,
  parameter int FlitTypeWidth           = 2,
  parameter int BroadcastWidth          = 1,
  parameter int NumberOfVirtualNetworks = 3,
  parameter int VirtualNetworkIdWidth   = 2
) (
  input  logic                                              clk_network_i,
  input  logic                                              rst_network_i,
  input  logic [NumberOfVirtualNetworks-1:0]                vn_valid_i,
  output logic [NumberOfVirtualNetworks-1:0]                vn_ready_o,
  input  logic [NumberOfVirtualNetworks*FlitWidth-1:0]      vn_flit_i,
  input  logic [NumberOfVirtualNetworks*FlitTypeWidth-1:0]  vn_flit_type_i,
  input  logic [NumberOfVirtualNetworks*BroadcastWidth-1:0] vn_broadcast_i,
  output logic                                              network_valid_o,
  input  logic                                              network_ready_i,
  output logic [FlitWidth-1:0]                              network_flit_o,
  output logic [FlitTypeWidth-1:0]                          network_flit_type_o,
  output logic [BroadcastWidth-1:0]                         network_broadcast_o,
  output logic [VirtualNetworkIdWidth-1:0]                  network_virtual_network_id_o,
  output logic                                              protocol_error_o
);

  localparam int N = NumberOfVirtualNetworks;
  localparam int W = VirtualNetworkIdWidth;

  state_t                    r_state, w_state_next;
  logic [W-1:0]              r_lock_vn, w_lock_vn_next;
  logic [W-1:0]              r_ptr, w_ptr_next;

  logic                      r_valid;
  logic [FlitWidth-1:0]      r_flit;
  logic [FlitTypeWidth-1:0]  r_type;
  logic [BroadcastWidth-1:0] r_bcast;
  logic [W-1:0]              r_vn_id;
  logic                      r_err;

  logic [FlitWidth-1:0]      w_flit  [N];
  logic [FlitTypeWidth-1:0]  w_type  [N];
  logic [BroadcastWidth-1:0] w_bcast [N];
  logic [N-1:0]              w_eligible, w_illegal;

  logic [N-1:0]              w_rr_grant, w_sel_oh;
  logic [W-1:0]              w_rr_idx, w_sel_idx;
  logic                      w_rr_valid;
  logic                      w_can_load, w_sel_valid, w_load, w_err;
  logic [FlitWidth-1:0]      w_flit_sel;
  logic [FlitTypeWidth-1:0]  w_type_sel;
  logic [BroadcastWidth-1:0] w_bcast_sel;

  generate
    for (genvar k = 0; k < N; k++) begin : g_slice
      assign w_flit[k]     = vn_flit_i[vn_lsb(k, FlitWidth) +: FlitWidth];
      assign w_type[k]     = vn_flit_type_i[vn_lsb(k, FlitTypeWidth) +: FlitTypeWidth];
      assign w_bcast[k]    = vn_broadcast_i[vn_lsb(k, BroadcastWidth) +: BroadcastWidth];
      assign w_eligible[k] = vn_valid_i[k] && is_header_type(w_type[k]);
      assign w_illegal[k]  = vn_valid_i[k] && !is_header_type(w_type[k]);
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ   (N),
    .IDX_WIDTH (W)
  ) u_rr_arbiter (
    .i_req         (w_eligible),
    .i_ptr         (r_ptr),
    .o_grant       (w_rr_grant),
    .o_grant_idx   (w_rr_idx),
    .o_grant_valid (w_rr_valid)
  );

  assign w_can_load = !r_valid || network_ready_i;

  always_comb begin
    w_sel_oh       = '0;
    w_sel_idx      = r_lock_vn;
    w_sel_valid    = 1'b0;
    w_flit_sel     = '0;
    w_type_sel     = '0;
    w_bcast_sel    = '0;
    w_err          = 1'b0;
    w_state_next   = r_state;
    w_lock_vn_next = r_lock_vn;
    w_ptr_next     = r_ptr;
    vn_ready_o     = '0;

    if (r_state == IDLE) begin
      w_sel_oh    = w_rr_grant;
      w_sel_idx   = w_rr_idx;
      w_sel_valid = w_rr_valid;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (r_lock_vn == W'(k)) w_sel_oh[k] = 1'b1;
      end
      w_sel_valid = |(w_sel_oh & vn_valid_i);
    end

    for (int k = 0; k < N; k++) begin
      if (w_sel_oh[k]) begin
        w_flit_sel  = w_flit[k];
        w_type_sel  = w_type[k];
        w_bcast_sel = w_bcast[k];
      end
    end

    w_load     = w_can_load && w_sel_valid;
    vn_ready_o = w_sel_oh & {N{w_can_load}};

    if (r_state == IDLE) begin
      // Stray body/tail flits are swallowed regardless of output backpressure.
      vn_ready_o = vn_ready_o | w_illegal;
      w_err      = |w_illegal;
      if (w_load) begin
        w_ptr_next = (w_sel_idx == W'(N - 1)) ? '0 : w_sel_idx + 1'b1;
        if (w_type_sel == HEADER) begin
          w_state_next   = LOCKED;
          w_lock_vn_next = w_sel_idx;
        end
      end
    end else if (w_load) begin
      w_err = is_header_type(w_type_sel);
      if (w_type_sel == TAIL) w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk_network_i or posedge rst_network_i) begin
    if (rst_network_i) begin
      r_state   <= IDLE;
      r_lock_vn <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lock_vn <= w_lock_vn_next;
      r_ptr     <= w_ptr_next;
    end
  end

  // The error flag is registered with the output stage so every output is a flop.
  always_ff @(posedge clk_network_i or posedge rst_network_i) begin
    if (rst_network_i) begin
      r_valid <= 1'b0;
      r_flit  <= '0;
      r_type  <= '0;
      r_bcast <= '0;
      r_vn_id <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_load) begin
        r_valid <= 1'b1;
        r_flit  <= w_flit_sel;
        r_type  <= w_type_sel;
        r_bcast <= w_bcast_sel;
        r_vn_id <= w_sel_idx;
      end else if (network_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign network_valid_o              = r_valid;
  assign network_flit_o               = r_flit;
  assign network_flit_type_o          = r_type;
  assign network_broadcast_o          = r_bcast;
  assign network_virtual_network_id_o = r_vn_id;
  assign protocol_error_o             = r_err;

endmodule

`default_nettype wire
